// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the branch target buffer entry layout.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Tag is held zero-extended to 32 bits so the layout is independent of BTB size.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational; training happens on the clock edge.
module branch_target_buffer
  import cpu_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX = $clog2(ENTRIES);

  btb_entry_t entries [ENTRIES];

  logic [31:0]    l_word;
  logic [IDX-1:0] l_idx;
  logic [31:0]    l_tag;
  btb_entry_t     l_entry;

  logic [31:0]    u_word;
  logic [IDX-1:0] u_idx;
  logic [31:0]    u_tag;
  btb_entry_t     u_entry;
  logic           u_hit;

  // Word address first, so the byte offset drops out of both index and tag.
  always_comb begin
    l_word     = lookup_pc >> 2;
    l_idx      = l_word[IDX-1:0];
    l_tag      = l_word >> IDX;
    l_entry    = entries[l_idx];
    hit        = l_entry.valid && (l_entry.tag == l_tag);
    pred_taken = hit && l_entry.ctr[1];
    target     = l_entry.target;
  end

  always_comb begin
    u_word  = upd_pc >> 2;
    u_idx   = u_word[IDX-1:0];
    u_tag   = u_word >> IDX;
    u_entry = entries[u_idx];
    u_hit   = u_entry.valid && (u_entry.tag == u_tag);
  end

  // Only valid bits are reset; tag/target/ctr are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          entries[u_idx].ctr    <= (u_entry.ctr == ST) ? ST : u_entry.ctr + 2'd1;
          entries[u_idx].target <= upd_target;
        end else begin
          entries[u_idx].ctr <= (u_entry.ctr == SNT) ? SNT : u_entry.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        entries[u_idx].valid  <= 1'b1;
        entries[u_idx].tag    <= u_tag;
        entries[u_idx].target <= upd_target;
        entries[u_idx].ctr    <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC selection and BTB-based prediction.
// imem_addr is the next PC so the synchronous memory output always matches if_pc.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_update_valid,
  input  logic [31:0] ex_update_pc,
  input  logic [31:0] ex_update_target,
  input  logic        ex_update_taken,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        if_flush
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        btb_hit;
  logic        btb_pred;
  logic [31:0] btb_target;

  branch_target_buffer #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc),
    .hit        (btb_hit),
    .pred_taken (btb_pred),
    .target     (btb_target),
    .upd_valid  (ex_update_valid & ~rst),
    .upd_pc     (ex_update_pc),
    .upd_target (ex_update_target),
    .upd_taken  (ex_update_taken)
  );

  always_comb begin
    pc_next = pc + PC_INC;
    if (rst)              pc_next = RESET_PC;
    else if (ex_redirect) pc_next = ex_redirect_pc;
    else if (stall)       pc_next = pc;
    else if (btb_pred)    pc_next = btb_target;
  end

  always_ff @(posedge clk) begin
    pc <= pc_next;
  end

  // pred_taken already implies a hit; btb_hit is kept for visibility only.
  assign imem_addr     = pc_next;
  assign if_pc         = rst ? RESET_PC : pc;
  assign if_pred_taken = ~rst & ~ex_redirect & btb_pred & btb_hit;
  assign if_flush      = ex_redirect & ~rst;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC register and drives the synchronous instruction-memory address.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction.
- Presents if_pc, if_pred_taken and if_flush for IF/ID to capture. Accepts stall from the hazard unit and redirect/update from EX.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; this is the inverse of the IF/ID pipeline_en.
- ex_redirect  in  1  mispredict or jump resolved in EX; restart fetch.
- ex_redirect_pc  in  32  correct next PC.
- ex_update_valid  in  1  a branch resolved in EX this cycle; train the BTB.
- ex_update_pc  in  32  PC of the resolved branch.
- ex_update_target  in  32  resolved target address.
- ex_update_taken  in  1  resolved direction.
- imem_addr  out  32  address to the instruction memory, which registers its output.
- if_pc  out  32  PC of the instruction currently leaving the instruction memory.
- if_pred_taken  out  1  BTB predicted-taken for if_pc.
- if_flush  out  1  instruction at if_pc is wrong-path; IF/ID marks it as a bubble.

Behaviour:
- pc register: if_pc = pc.
- Memory timing: imem_addr = pc_next, combinational. The memory and pc sample together, so the memory output always corresponds to if_pc. Zero-bubble fetch.
- pc_next priority, highest first:
  - rst → RESET_PC.
  - ex_redirect → ex_redirect_pc.
  - stall → pc (re-present the same address so the memory output holds).
  - BTB hit with counter[1]=1 → stored target.
  - otherwise → pc+4, wrapping modulo 2^32.
- pc <= pc_next on every clock edge. During reset, if_pc = RESET_PC and imem_addr = RESET_PC.
- if_pred_taken = ~rst & hit & counter[1], combinational from pc. Forced to 0 when ex_redirect=1.
- if_flush = ex_redirect & ~rst. The combinational pulse is captured by IF/ID.
- BTB indexing:
  - index = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - tag = pc[31:IDX+2].
  - pc[1:0] are ignored.
  - hit = valid & tag match.
- BTB entry: valid, tag, 32-bit target, 2-bit counter.
- BTB reset: all valid bits cleared. Targets, tags and counters need no reset.
- BTB update (on a clock edge when ex_update_valid=1, indexed by ex_update_pc):
  - Hit, taken: counter saturating increment (max 3); target overwritten.
  - Hit, not taken: counter saturating decrement (min 0).
  - Miss, taken: allocate/replace; valid=1, new tag and target, counter=2.
  - Miss, not taken: no change.
- Updates apply regardless of stall and ex_redirect. Suppressed during rst.
- Same-cycle lookup and update of the same index: lookup sees pre-update state; the write takes effect at the edge.
- Counter encoding: 0 strong not-taken, 1 weak not-taken, 2 weak taken, 3 strong taken.
- Reset mid-operation: any pending redirect and all prediction state are discarded; fetch restarts at RESET_PC.

Decomposition:
- Shared package cpu_pkg:
  - Constants RESET_PC_DEFAULT and PC_INC=4.
  - BTB counter localparams: SNT=0, WNT=1, WT=2, ST=3.
  - Typedef btb_entry_t {valid, tag, target, ctr}.
- One sub-module: branch_target_buffer.
  - Combinational lookup port: pc → hit, pred_taken, target.
  - Synchronous update port.
- PC mux and register stay in fetch_unit.

Test Plan:
- Reset: hold rst 2 cycles, then release → during rst if_pc=0, imem_addr=0, if_pred_taken=0, if_flush=0; after release if_pc steps 0, 4, 8, 12 on consecutive cycles.
- Stall: assert stall 3 cycles while if_pc=0x8 → if_pc=0x8 and imem_addr=0x8 throughout; cycle after release imem_addr=0xC.
- Redirect: ex_redirect=1, ex_redirect_pc=0x100 while if_pc=0x10 → same cycle if_flush=1 and imem_addr=0x100; next cycle if_pc=0x100; redirect with stall=1 still gives 0x100.
- BTB allocate/predict:
  - Update pc=0x20, target=0x80, taken=1.
  - On the later fetch of 0x20 → if_pred_taken=1, imem_addr=0x80, next if_pc=0x80.
  - Fetch of 0x420 (same index, different tag) → if_pred_taken=0, imem_addr=0x424.
- Counter training: from counter=2 at 0x20, one not-taken update → prediction 0 (ctr=1); two taken updates → ctr=3; one not-taken → still predicts taken (ctr=2); 0→0 and 3→3 saturate.
- Same-cycle hazard: update not-taken for 0x20 in the same cycle that 0x20 is fetched with ctr=2 → that fetch predicts taken; next fetch of 0x20 predicts not-taken.
